// File: rtl/mem_arbiter.sv
// Arbitrates IF/LS onto one memory port, one transaction at a time; accept-to-response is 4 cycles minimum, no back-to-back accepts.
// Request channels are valid/ready (ready only in IDLE); response pulses have no backpressure. ARB_ROUND_ROBIN_EN selects round-robin over fixed LS priority.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t                state, state_nxt;
  logic                  owner;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  grant_if, grant_ls;
  logic                  accept;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clock) begin
    if (!reset)
      last_grant <= OWN_LS;
    else if (accept)
      last_grant <= grant_ls;
  end

  // On contention the requester not granted last time wins.
  always_comb begin
    grant_ls = ls_req_valid && (!if_req_valid || (last_grant == OWN_IF));
    grant_if = if_req_valid && !grant_ls;
  end
`else
  always_comb begin
    grant_ls = ls_req_valid;
    grant_if = if_req_valid && !ls_req_valid;
  end
`endif

  // Gated by reset so no ready is offered while reset is held.
  assign accept = reset && (state == IDLE) && (if_req_valid || ls_req_valid);

  always_ff @(posedge clock) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (mem_req_ready) state_nxt = WAIT;
      WAIT:    if (mem_resp_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_req_ready  = accept && grant_if;
    ls_req_ready  = accept && grant_ls;
    mem_req_valid = (state == REQ);
    if_resp_valid = (state == RESP) && (owner == OWN_IF);
    ls_resp_valid = (state == RESP) && (owner == OWN_LS);
    busy          = (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      owner   <= OWN_IF;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        owner   <= grant_ls ? OWN_LS : OWN_IF;
        addr_q  <= grant_ls ? ls_req_addr : if_req_addr;
        wen_q   <= grant_ls && ls_req_wen;
        wdata_q <= grant_ls ? ls_req_wdata : '0;
        wmask_q <= grant_ls ? ls_req_wmask : '0;
      end
      // Responses arriving outside WAIT are dropped.
      if ((state == WAIT) && mem_resp_valid)
        rdata_q <= mem_resp_data;
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign if_resp_data  = rdata_q;
  assign ls_resp_data  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, IF read, stalled LS write, spurious response/mid-op reset, contention.
module tb_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_req_addr, if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_resp_data;
  logic [7:0]  ls_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [7:0]  mem_req_wmask;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) step();
    checks++; if (if_req_ready !== 1'b0) begin failures++; $display("FAIL rst_if_ready got=%b exp=0", if_req_ready); end
    checks++; if (ls_req_ready !== 1'b0) begin failures++; $display("FAIL rst_ls_ready got=%b exp=0", ls_req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%b exp=0", mem_req_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (mem_req_addr !== 64'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_req_addr); end
    reset = 1'b1;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin failures++; $display("FAIL rst_first_accept got=%b exp=1", if_req_ready); end
    step();
    if_req_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin
      failures++; $display("FAIL rst_first_req valid=%b addr=%h exp valid=1 addr=80000000", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h1;
    step();
    mem_resp_valid = 1'b0;
    checks++; if (if_resp_valid !== 1'b1) begin failures++; $display("FAIL rst_first_resp got=%b exp=1", if_resp_valid); end
    step();
  endtask

  task automatic test_single_if();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin failures++; $display("FAIL if_accept got=%b exp=1", if_req_ready); end
    step(); // N+1
    if_req_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL if_mem_valid got=%b exp=1", mem_req_valid); end
    checks++; if (mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00) begin
      failures++; $display("FAIL if_wen_mask wen=%b mask=%h exp 0/00", mem_req_wen, mem_req_wmask); end
    checks++; if (mem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL if_addr got=%h exp=80000000", mem_req_addr); end
    mem_req_ready = 1'b1;
    step(); // N+2
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h00000413_00000297;
    checks++; if (if_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL if_wait resp=%b memv=%b exp 0/0", if_resp_valid, mem_req_valid); end
    step(); // N+3
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    checks++; if (if_resp_valid !== 1'b1 || ls_resp_valid !== 1'b0) begin
      failures++; $display("FAIL if_resp_pulse if=%b ls=%b exp 1/0", if_resp_valid, ls_resp_valid); end
    checks++; if (if_resp_data !== 64'h00000413_00000297) begin
      failures++; $display("FAIL if_resp_data got=%h exp=0000041300000297", if_resp_data); end
    step(); // N+4
    checks++; if (if_resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL if_after resp=%b busy=%b exp 0/0", if_resp_valid, busy); end
  endtask

  task automatic test_ls_write_delayed();
    int resp_cycle = -1;
    int pulses = 0;
    logic [63:0] got_data = '0;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_1000; ls_req_wen = 1'b1;
    ls_req_wdata = 64'h0000_0000_DEAD_BEEF; ls_req_wmask = 8'h0F;
    #1;
    checks++; if (ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
      failures++; $display("FAIL ls_accept ls=%b if=%b exp 1/0", ls_req_ready, if_req_ready); end
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        ls_req_valid = 1'b0; ls_req_addr = 64'h1234; ls_req_wen = 1'b0;
        ls_req_wdata = '1; ls_req_wmask = 8'hFF;
      end
      if (c <= 3) begin
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_1000 || mem_req_wen !== 1'b1 ||
            mem_req_wdata !== 64'h0000_0000_DEAD_BEEF || mem_req_wmask !== 8'h0F) begin
          failures++;
          $display("FAIL ls_stall_fields c=%0d v=%b a=%h w=%b d=%h m=%h exp 1/80001000/1/deadbeef/0f",
                   c, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
        end
      end
      if (ls_resp_valid) begin
        pulses++;
        if (resp_cycle < 0) begin resp_cycle = c; got_data = ls_resp_data; end
      end
      mem_req_ready  = (c == 3);
      mem_resp_valid = (c == 6);
      mem_resp_data  = (c == 6) ? 64'h0000_0000_0000_0ACC : 64'h0;
    end
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    checks++; if (resp_cycle != 7) begin failures++; $display("FAIL ls_resp_cycle got=%0d exp=7", resp_cycle); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL ls_resp_pulses got=%0d exp=1", pulses); end
    checks++; if (got_data !== 64'h0ACC) begin failures++; $display("FAIL ls_resp_data got=%h exp=acc", got_data); end
  endtask

  task automatic test_spurious_and_reset();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0040;
    step(); // REQ, requester keeps valid high
    mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD;
    step();
    checks++; if (mem_req_valid !== 1'b1 || if_resp_valid !== 1'b0) begin
      failures++; $display("FAIL spur_ignored memv=%b resp=%b exp 1/0", mem_req_valid, if_resp_valid); end
    checks++; if (if_req_ready !== 1'b0) begin failures++; $display("FAIL ready_outside_idle got=%b exp=0", if_req_ready); end
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1; if_req_valid = 1'b0;
    step(); // WAIT
    mem_req_ready = 1'b0;
    checks++; if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL spur_wait busy=%b memv=%b exp 1/0", busy, mem_req_valid); end
    reset = 1'b0;
    step();
    reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h5555;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_idle busy=%b exp=0", busy); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL midrst_no_resp c=%0d if=%b ls=%b busy=%b exp 0/0/0", c, if_resp_valid, ls_resp_valid, busy); end
    end
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic test_contention();
    logic exp_ls [4];
    int n = 0;
    int last_c = -1;
    int c = 0;
    logic if_got = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_ls = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0100;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_2000; ls_req_wen = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h77;
    #1;
    while (n < 4 && c < 40) begin
      if (if_req_ready || ls_req_ready) begin
        checks++; if (if_req_ready && ls_req_ready) begin failures++; $display("FAIL cont_double_grant n=%0d", n); end
        checks++; if (ls_req_ready !== exp_ls[n]) begin
          failures++; $display("FAIL cont_order n=%0d got_ls=%b exp_ls=%b", n, ls_req_ready, exp_ls[n]); end
        if (last_c >= 0) begin
          checks++; if (c - last_c != 4) begin failures++; $display("FAIL cont_spacing got=%0d exp=4", c - last_c); end
        end
        last_c = c;
        n++;
      end
      if (n < 4) begin step(); c++; end
    end
    checks++; if (n != 4) begin failures++; $display("FAIL cont_timeout grants=%0d exp=4", n); end
    step();
    ls_req_valid = 1'b0;
    for (int k = 0; k < 10 && !if_got; k++) begin
      if (if_req_ready) if_got = 1'b1;
      else step();
    end
    checks++; if (if_got !== 1'b1) begin failures++; $display("FAIL cont_if_after_ls_drop got=%b exp=1", if_got); end
    step();
    if_req_valid = 1'b0;
    for (int k = 0; k < 10 && busy; k++) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_drain busy=%b exp=0", busy); end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_if();
    test_ls_write_delayed();
    test_spurious_and_reset();
    test_contention();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single physical memory port between instruction fetch (IF) and load/store (LS) requesters. Accepts one transaction at a time through valid/ready request channels, forwards it to the memory port, waits for the variable-latency response, and returns it to the owning requester as a one-cycle pulse. Sits between the IFU/LSU and the DPI-backed memory model. With this block, fetch becomes a multi-cycle handshake instead of a same-cycle read.

## Interface
Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, data width; wmask width is DATA_W/8

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- if_req_valid  in  1  IF request pending
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  ADDR_W  IF address (8-byte aligned by requester)
- if_resp_valid  out  1  IF response pulse
- if_resp_data  out  DATA_W  IF response data
- ls_req_valid  in  1  LS request pending
- ls_req_ready  out  1  LS request accepted this cycle
- ls_req_addr  in  ADDR_W  LS address
- ls_req_wen  in  1  1 = write, 0 = read
- ls_req_wdata  in  DATA_W  write data
- ls_req_wmask  in  DATA_W/8  byte write mask
- ls_resp_valid  out  1  LS response pulse (read data or write ack)
- ls_resp_data  out  DATA_W  LS response data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  latched address
- mem_req_wen  out  1  latched write enable (always 0 for IF)
- mem_req_wdata  out  DATA_W  latched write data
- mem_req_wmask  out  DATA_W/8  latched mask (0 for IF)
- mem_resp_valid  in  1  memory response
- mem_resp_data  in  DATA_W  memory response data
- busy  out  1  state != IDLE

## Operation
- One outstanding transaction. FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any req_valid, choose winner; assert winner's req_ready combinationally in the same cycle; latch addr/wen/wdata/wmask and owner; go to REQ. Loser's ready stays 0.
- REQ: mem_req_valid=1 with latched fields held stable. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, latch mem_resp_data and go to RESP.
- RESP: owner's resp_valid=1 for exactly one cycle with latched data; then IDLE.
- resp_valid has no backpressure; requesters must consume the pulse.
- mem_resp_valid outside WAIT is ignored.
- All req_ready outputs are 0 outside IDLE.
- Write response: ls_resp_valid pulses as an ack; ls_resp_data = captured mem_resp_data.
- A single valid requester always wins.
- Reset values: all outputs 0, state IDLE, owner field = IF, last-grant = LS, data registers 0.
- Reset asserted mid-transaction: the next clock edge returns the FSM to IDLE; the transaction is dropped and no resp pulse is produced.

## Timing
- Accept cycle N (ready=1).
- mem_req_valid from cycle N+1.
- With mem_req_ready=1 at N+1 and mem_resp_valid=1 at N+2, resp_valid is seen at N+3. Minimum turnaround is 4 cycles.
- Every added cycle of mem_req_ready or mem_resp_valid delay adds exactly one cycle.
- Next acceptance is possible at N+4 (first IDLE cycle after RESP); there is no back-to-back acceptance.
- The winner is decided only from the req_valid values sampled in IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both request, the requester not granted last wins.
  - last-grant updates on every acceptance.
  - Reset last-grant = LS, so IF wins the first contended cycle.
- Undefined:
  - Fixed priority, LS over IF on contention.
  - last-grant register is not implemented.

## Test plan
- Reset sequence:
  - reset=0 held 3 cycles with if_req_valid=1 → both readies 0, mem_req_valid 0, busy 0.
  - On reset=1, IF is accepted in the first cycle.
- Single IF read:
  - Stimulus: if_req_addr=0x80000000; memory ready immediately, resp 1 cycle later with data 0x00000413_00000297.
  - Required: if_resp_valid pulses at accept+3 with that data; mem_req_wen=0, wmask=0.
- LS write with delayed memory:
  - Stimulus: addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F; mem_req_ready after 2 stall cycles, resp after 3.
  - Required: latched fields are stable through all stalls; ls_resp_valid at accept+1+3+3 cycles (cycle 7 after accept).
- Contention, both valid continuously for 4 transactions:
  - With ARB_ROUND_ROBIN_EN: grant order IF, LS, IF, LS.
  - Without ARB_ROUND_ROBIN_EN: LS, LS, LS, LS, with IF starved until ls_req_valid drops.
- Spurious response and mid-operation reset:
  - mem_resp_valid=1 in REQ → ignored; state stays REQ.
  - reset=0 during WAIT → next cycle IDLE; no resp pulse even if mem_resp_valid=1 arrives.
